// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage; owns the PC, issues imem requests and drives IF/ID.
// Ports: clk, rst_n (sync, active-low); pcwrite/IFwrite stall, IFflush + branch_target redirect;
// imem_req/imem_addr/imem_rdata/imem_ready multi-cycle memory handshake;
// IF_ID_instr/IF_ID_pc4/IF_ID_valid pipeline register.
// FETCH_PERF_CNT_EN adds perf_stall_cycles and perf_flush_count (saturating counters).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcwrite,
  input  logic        IFwrite,
  input  logic        IFflush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, pc4, redirect_pc, redirect_n, hold_instr, hold_n;
  logic advance, bubble, load;
  assign advance = pcwrite & IFwrite;
  assign pc4 = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req = rst_n & (state != HOLD);
  always_comb begin
    state_n = state;
    pc_n = pc;
    redirect_n = redirect_pc;
    hold_n = hold_instr;
    bubble = 1'b0;
    load = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ready) begin
          if (IFflush) begin
            bubble = 1'b1;
            pc_n = branch_target;
          end else if (advance) begin
            load = 1'b1;
            pc_n = pc4;
          end else begin
            hold_n = imem_rdata;
            state_n = HOLD;
          end
        end else if (IFflush) begin
          bubble = 1'b1;
          redirect_n = branch_target;
          state_n = DISCARD;
        end else begin
          bubble = IFwrite;
        end
      end
      HOLD: begin
        if (IFflush) begin
          bubble = 1'b1;
          pc_n = branch_target;
          hold_n = '0;
          state_n = FETCH;
        end else if (advance) begin
          load = 1'b1;
          pc_n = pc4;
          state_n = FETCH;
        end
      end
      DISCARD: begin
        bubble = 1'b1;
        redirect_n = IFflush ? branch_target : redirect_pc;
        if (imem_ready) begin
          pc_n = IFflush ? branch_target : redirect_pc;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc <= RESET_PC;
      redirect_pc <= '0;
      hold_instr <= '0;
      IF_ID_instr <= '0;
      IF_ID_pc4 <= '0;
      IF_ID_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      redirect_pc <= redirect_n;
      hold_instr <= hold_n;
      IF_ID_instr <= bubble ? '0 : load ? (state == HOLD ? hold_instr : imem_rdata) : IF_ID_instr;
      IF_ID_pc4 <= bubble ? '0 : load ? pc4 : IF_ID_pc4;
      IF_ID_valid <= bubble ? 1'b0 : load ? 1'b1 : IF_ID_valid;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_count <= '0;
    end else begin
      if (!advance && !IFflush && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (IFflush && perf_flush_count != '1) perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif
endmodule

// File: doc/fetch_stage.md
# fetch_stage

IF stage of the five-stage MIPS pipeline: owns the PC, issues instruction-memory requests, and drives the IF/ID pipeline register. It consumes the stall (`pcwrite`, `IFwrite`) and flush (`IFflush`) controls that the hazard detection unit produces, so it is the receiving end of the hazard interface. It tolerates a multi-cycle instruction memory, and it discards a wrong-path fetch that is still in flight when a branch redirect arrives.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `pcwrite` in 1: 0 = hold the PC (load-use stall).
- `IFwrite` in 1: 0 = hold IF/ID.
- `IFflush` in 1: taken branch resolved in ID; squash IF and redirect.
- `branch_target` in 32: redirect PC; valid when `IFflush`=1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_rdata` in 32: instruction; valid when `imem_ready`=1.
- `imem_ready` in 1: completes the outstanding request this cycle.
- `IF_ID_instr` out 32: latched instruction; 0 (nop) for a bubble.
- `IF_ID_pc4` out 32: PC+4 of the latched instruction.
- `IF_ID_valid` out 1: 1 = real instruction, 0 = bubble.

## Operation
- Registers:
  - `pc`, `redirect_pc`, `hold_instr`.
  - IF/ID triple {instr, pc4, valid}.
  - State register with states FETCH, HOLD, DISCARD.
- `advance` = `pcwrite & IFwrite`. If the two inputs disagree, the stage treats it as a stall.
- Priority in every state: `IFflush` > stall > advance.
- "Bubble" means IF/ID <= {0, 0, 0}.
- `imem_req` = 1 in FETCH and DISCARD, 0 in HOLD. `imem_addr` = `pc` at all times.

FETCH:
- ready & flush: bubble; `pc` <= `branch_target`; stay FETCH.
- ready & advance: IF/ID <= {`imem_rdata`, `pc`+4, 1}; `pc` <= `pc`+4.
- ready & stall: `hold_instr` <= `imem_rdata`; IF/ID unchanged; go HOLD.
- !ready & flush: bubble; `redirect_pc` <= `branch_target`; go DISCARD.
- !ready & `IFwrite`=1: bubble.
- !ready & `IFwrite`=0: IF/ID unchanged.

HOLD:
- flush: bubble; `pc` <= `branch_target`; drop `hold_instr`; go FETCH.
- advance: IF/ID <= {`hold_instr`, `pc`+4, 1}; `pc` <= `pc`+4; go FETCH.
- else: stay; nothing changes.

DISCARD:
- IF/ID is bubbled every cycle.
- flush again: `redirect_pc` <= `branch_target` (latest wins).
- ready: `imem_rdata` is dropped; `pc` <= `redirect_pc`, or `branch_target` if `IFflush` is asserted the same cycle; go FETCH.

Arithmetic:
- PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- `pc` bits [1:0] are taken as-is from `branch_target`; no alignment check.

## Timing
- Reset values (`rst_n`=0 at an edge):
  - `pc`=`RESET_PC`, `redirect_pc`=0, `hold_instr`=0.
  - IF/ID={0,0,0`}; state=FETCH.
  - `imem_req`=0 while `rst_n`=0. The first request (`addr`=`RESET_PC`) is presented in the first cycle with `rst_n`=1.
- Latency:
  - Zero-wait memory (`imem_ready`=1 in the same cycle as `imem_req`): one instruction per cycle. Instruction fetched in cycle N appears on IF/ID in cycle N+1.
  - N wait cycles: N bubbles are inserted when `IFwrite`=1.
- Flush latency: the cycle after `IFflush` shows a bubble on IF/ID. With zero-wait memory, the first fetch from `branch_target` is issued in that same cycle.
- Reset mid-DISCARD or mid-HOLD:
  - Pending redirect and held instruction are lost.
  - The memory must abandon the in-flight request when it sees `imem_req`=0 during reset.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds two outputs, both reset to 0 and saturating at 32'hFFFF_FFFF:
  - `perf_stall_cycles` out 32: +1 each cycle with `advance`=0 and `IFflush`=0.
  - `perf_flush_count` out 32: +1 each cycle with `IFflush`=1.
- Undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000, zero-wait memory returning `addr`^32'hA5A5_A5A5, advance always.
  - `imem_addr` sequence: 400000, 400004, 400008.
  - IF_ID {instr, pc4} tracks each fetch one cycle later; valid=1 from the second cycle.
- Stall while the fetch of `pc`=0x10 is ready (`pcwrite`=`IFwrite`=0) for 2 cycles:
  - state HOLD; `imem_req`=0; IF/ID held.
  - On release, IF/ID={mem[0x10], 0x14, 1}; next `imem_addr`=0x14.
- `IFflush`=1 with `branch_target`=0x200 and a zero-wait fetch:
  - next cycle IF/ID valid=0, instr=0; `imem_addr`=0x200.
- `IFflush` with target 0x300 while a fetch of 0x40 is pending 3 wait cycles:
  - `imem_addr` stays 0x40 until ready; the returned word is dropped.
  - Next request is 0x300; IF/ID is a bubble throughout.
- Simultaneous `IFflush` and stall (`pcwrite`=0) in HOLD: flush wins; bubble; `pc`=target.
- Wrap: `pc`=32'hFFFF_FFFC with advance → `IF_ID_pc4`=0 and next `imem_addr`=0.
- With `FETCH_PERF_CNT_EN`: 3 stall cycles and 2 flushes give `perf_stall_cycles`=3, `perf_flush_count`=2.
